// File: rtl/tick_pkg.sv
// Shared defaults and helpers for the multi-channel tick generator.
package tick_pkg;

  localparam int DEFAULT_CLK_HZ  = 50_000_000;
  localparam int DEFAULT_BASE_HZ = 1000;
  localparam int DEFAULT_CNT_W   = 16;

  // Width of a prescaler counter spanning 0..PRE-1; never narrower than one bit.
  function automatic int pre_width(input int clk_hz, input int base_hz);
    int pre;
    pre = clk_hz / base_hz;
    return (pre < 2) ? 1 : $clog2(pre);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One divider channel: counts base ticks and emits a one-cycle tick plus a square wave.
module tick_channel #(
  parameter int CNT_W     = 16,
  parameter int DIV_RESET = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrap_i,
  input  logic             sync_clr_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] wval_i,
  output logic             tick_o,
  output logic             sq_o
);

  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_nxt_q, div_nxt_d;
  logic [CNT_W-1:0] ccnt_q, ccnt_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             active;
  logic             term_cnt;

  // NOTE: every next-state signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
  always_comb begin
    div_act_d = div_act_q;
    div_nxt_d = div_nxt_q;
    ccnt_d    = ccnt_q;
    sq_d      = sq_q;
    tick_d    = 1'b0;
    active    = (div_act_q != '0);
    term_cnt  = wrap_i && active && (ccnt_q == div_act_q - CNT_W'(1));

    if (sync_clr_i) begin
      ccnt_d    = '0;
      sq_d      = 1'b0;
      div_act_d = div_nxt_q;
    end else if (term_cnt) begin
      ccnt_d    = '0;
      div_act_d = div_nxt_q;
      tick_d    = 1'b1;
      sq_d      = ~sq_q;
    end else if (wrap_i && active) begin
      ccnt_d = ccnt_q + CNT_W'(1);
    end

    // A terminal count on this edge has already consumed the old shadow value.
    if (we_i) begin
      div_nxt_d = wval_i;
      if (!active) begin
        div_act_d = wval_i;
        ccnt_d    = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_act_q <= CNT_W'(DIV_RESET);
      div_nxt_q <= CNT_W'(DIV_RESET);
      ccnt_q    <= '0;
      tick_q    <= 1'b0;
      sq_q      <= 1'b0;
    end else begin
      div_act_q <= div_act_d;
      div_nxt_q <= div_nxt_d;
      ccnt_q    <= ccnt_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
    end
  end

  assign tick_o = tick_q;
  assign sq_o   = sq_q;

endmodule

// File: rtl/tick_gen_multi.sv
// Prescaler producing a base tick, feeding NUM_CH independently programmable divider channels.
module tick_gen_multi
  import tick_pkg::*;
#(
  parameter int CLK_HZ    = DEFAULT_CLK_HZ,
  parameter int BASE_HZ   = DEFAULT_BASE_HZ,
  parameter int NUM_CH    = 3,
  parameter int CNT_W     = DEFAULT_CNT_W,
  parameter int DIV_RESET = 1000
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          en,
  input  logic                                          sync_clr,
  input  logic                                          div_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] div_sel,
  input  logic [CNT_W-1:0]                              div_val,
  output logic                                          tick_base,
  output logic [NUM_CH-1:0]                             tick_ch,
  output logic [NUM_CH-1:0]                             sq_ch
);

  localparam int PRE   = CLK_HZ / BASE_HZ;
  localparam int PW    = pre_width(CLK_HZ, BASE_HZ);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRE - 1);

  if (CLK_HZ % BASE_HZ != 0) begin : g_bad_ratio
    $error("tick_gen_multi: CLK_HZ must be an integer multiple of BASE_HZ");
  end
  if (PRE < 2) begin : g_bad_pre
    $error("tick_gen_multi: CLK_HZ/BASE_HZ must be at least 2");
  end
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("tick_gen_multi: NUM_CH must be at least 1");
  end
  if (longint'(DIV_RESET) >= (64'd1 << CNT_W)) begin : g_bad_div_reset
    $error("tick_gen_multi: DIV_RESET does not fit in CNT_W bits");
  end

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          tick_base_q, tick_base_d;
  logic          wrap;

  always_comb begin
    pcnt_d      = pcnt_q;
    wrap        = en && (pcnt_q == PCNT_LAST);
    tick_base_d = wrap && !sync_clr;
    if (sync_clr || wrap) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = pcnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q      <= '0;
      tick_base_q <= 1'b0;
    end else begin
      pcnt_q      <= pcnt_d;
      tick_base_q <= tick_base_d;
    end
  end

  assign tick_base = tick_base_q;

  // Out-of-range selects match no channel index and are silently dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic we_ch;
    assign we_ch = div_we && (div_sel == SEL_W'(g));

    tick_channel #(
      .CNT_W     (CNT_W),
      .DIV_RESET (DIV_RESET)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .wrap_i     (wrap),
      .sync_clr_i (sync_clr),
      .we_i       (we_ch),
      .wval_i     (div_val),
      .tick_o     (tick_ch[g]),
      .sq_o       (sq_ch[g])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench: PRE=5, divisor 3 at reset; cycle n is the interval after edge n-1.
module tb_tick_gen_multi;

  logic       clk = 1'b0;
  logic       rst_n, en, sync_clr, div_we, div_we3;
  logic [0:0] div_sel;
  logic [1:0] div_sel3;
  logic [7:0] div_val;
  logic       tick_base, tick_base3;
  logic [1:0] tick_ch, sq_ch;
  logic [2:0] tick_ch3, sq_ch3;

  int cyc     = 0;
  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  tick_gen_multi #(
    .CLK_HZ(5000), .BASE_HZ(1000), .NUM_CH(2), .CNT_W(8), .DIV_RESET(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
    .div_we(div_we), .div_sel(div_sel), .div_val(div_val),
    .tick_base(tick_base), .tick_ch(tick_ch), .sq_ch(sq_ch)
  );

  // Three-channel instance so that an out-of-range select is expressible.
  tick_gen_multi #(
    .CLK_HZ(5000), .BASE_HZ(1000), .NUM_CH(3), .CNT_W(8), .DIV_RESET(3)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
    .div_we(div_we3), .div_sel(div_sel3), .div_val(div_val),
    .tick_base(tick_base3), .tick_ch(tick_ch3), .sq_ch(sq_ch3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    vectors++;
    assert (obs === expd) else begin
      errs++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, expd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_cycle(input logic b, input logic [1:0] t, input logic [1:0] s);
    check("tick_base", 32'(tick_base), 32'(b));
    check("tick_ch",   32'(tick_ch),   32'(t));
    check("sq_ch",     32'(sq_ch),     32'(s));
  endtask

  // Leaves the bench just before edge 0 with rst_n=1, en=1.
  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0;
    div_we = 1'b0; div_sel = '0; div_val = '0;
    div_we3 = 1'b0; div_sel3 = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_tick_base", 32'(tick_base), 32'd0);
    check("rst_tick_ch",   32'(tick_ch),   32'd0);
    check("rst_sq_ch",     32'(sq_ch),     32'd0);
    check("rst_sq_ch3",    32'(sq_ch3),    32'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    cyc   = 0;
  endtask

  function automatic logic every(input int c, input int first, input int per);
    return (c >= first) && ((c - first) % per == 0);
  endfunction

  // Square wave that first rises at `first` and toggles every `per` cycles.
  function automatic logic sqp(input int c, input int first, input int per);
    return (c >= first) && (((c - first) / per) % 2 == 0);
  endfunction

  initial begin
    // Free run with the reset divisor of 3.
    do_reset();
    for (int k = 0; k < 32; k++) begin
      tick();
      chk_cycle(every(cyc, 5, 5), {2{every(cyc, 15, 15)}}, {2{sqp(cyc, 15, 15)}});
    end

    // ch1 <- 1 at cycle 2: ch1 keeps its first period, then ticks on every base tick.
    do_reset();
    for (int k = 0; k < 32; k++) begin
      div_we = (cyc == 2); div_sel = 1'b1; div_val = 8'd1;
      tick();
      chk_cycle(every(cyc, 5, 5),
                {every(cyc, 15, 5), every(cyc, 15, 15)},
                {sqp(cyc, 15, 5),   sqp(cyc, 15, 15)});
    end

    // ch0 <- 0 disables after cycle 15; ch0 <- 2 at cycle 32 restarts it (ticks 40, 50).
    do_reset();
    for (int k = 0; k < 52; k++) begin
      div_we = (cyc == 2) || (cyc == 32); div_sel = 1'b0;
      div_val = (cyc == 2) ? 8'd0 : 8'd2;
      tick();
      chk_cycle(every(cyc, 5, 5),
                {every(cyc, 15, 15), (cyc == 15) || every(cyc, 40, 10)},
                {sqp(cyc, 15, 15),   ((cyc >= 15) && (cyc < 40)) || (cyc >= 50)});
    end

    // en low for edges 12..18: counts freeze, next base tick at cycle 22.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      en = !((cyc >= 12) && (cyc < 19));
      tick();
      chk_cycle((cyc == 5) || (cyc == 10) || every(cyc, 22, 5),
                {2{every(cyc, 22, 15)}}, {2{sqp(cyc, 22, 15)}});
    end

    // ch1 shadow <- 1 at cycle 2, sync_clr at cycle 13 promotes it and restarts everything.
    do_reset();
    for (int k = 0; k < 46; k++) begin
      sync_clr = (cyc == 13);
      div_we = (cyc == 2); div_sel = 1'b1; div_val = 8'd1;
      tick();
      chk_cycle((cyc == 5) || (cyc == 10) || every(cyc, 19, 5),
                {every(cyc, 19, 5), every(cyc, 29, 15)},
                {sqp(cyc, 19, 5),   sqp(cyc, 29, 15)});
    end
    sync_clr = 1'b0;

    // Out-of-range select on the three-channel instance changes nothing.
    do_reset();
    for (int k = 0; k < 32; k++) begin
      div_we3 = (cyc == 2); div_sel3 = 2'd3; div_val = 8'd1;
      tick();
      check("oor_tick_base", 32'(tick_base3), 32'(every(cyc, 5, 5)));
      check("oor_tick_ch",   32'(tick_ch3),   32'({3{every(cyc, 15, 15)}}));
      check("oor_sq_ch",     32'(sq_ch3),     32'({3{sqp(cyc, 15, 15)}}));
    end
    div_we3 = 1'b0;

    // ch0 <- 1 on the terminal-count edge 14: old period repeats once, then divisor 1.
    do_reset();
    for (int k = 0; k < 42; k++) begin
      div_we = (cyc == 14); div_sel = 1'b0; div_val = 8'd1;
      tick();
      chk_cycle(every(cyc, 5, 5),
                {every(cyc, 15, 15), (cyc == 15) || every(cyc, 30, 5)},
                {sqp(cyc, 15, 15),
                 ((cyc >= 15) && (cyc < 30)) || ((cyc >= 35) && (cyc < 40))});
    end
    div_we = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
